rs232_tx_arbiter: RTL and testbench

//  Shares one RS-232 serial transmitter among NUM_REQ byte producers.

---
 rtl/rs232_tx_arbiter_pkg.sv | 14 +
 rtl/rs232_tx_arbiter_baud_tick.sv | 30 +++
 rtl/rs232_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_tx_arbiter_pkg.sv
// Shared definitions for the shared RS-232 transmitter: frame states and line levels.
package rs232_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/rs232_tx_arbiter_baud_tick.sv
// Bit-period timer: counts 0..CLK_DIV-1 and pulses tick for one cycle on the wrap.
// A synchronous clear holds the count at zero so every frame starts on a fresh bit period.
module rs232_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Baud counter: cleared while idle, wraps at the end of each bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin shared RS-232 transmitter: picks one of NUM_REQ byte producers and
// serialises its byte as start bit, LSB-first data bits and stop bit(s) on txd_out.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_out,
    output logic                         busy_out,
    output logic                         txd_out
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      grant;
    logic                 any_valid;
    logic                 handshake;
    logic [DATA_BITS-1:0] win_data;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 txd;
    logic                 txd_next;
    logic                 tick;
    logic                 last_bit;

    rs232_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk  (clk_in),
        .rst_n(rst_n_in),
        .clear(state == IDLE),
        .tick (tick)
    );

    // Rotating-priority search: first valid requester at or after rr_ptr.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        win_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_valid && req_valid_in[idx]) begin
                any_valid = 1'b1;
                winner    = idx[ID_W-1:0];
                win_data  = req_data_in[idx*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // One-hot accept toward the winner, offered only while the line is free.
    always_comb begin
        req_ready_out = '0;
        if (rst_n_in && state == IDLE && any_valid) begin
            req_ready_out[winner] = 1'b1;
        end
    end

    assign handshake = (state == IDLE) && any_valid;
    assign last_bit  = ((state == DATA) && bit_cnt == LAST_DATA) ||
                       ((state == STOP) && bit_cnt == LAST_STOP);

    // Frame state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame sequencing and the line level each state drives.
    always_comb begin
        state_next = state;
        txd_next   = TXD_IDLE;
        case (state)
            IDLE: begin
                if (any_valid) state_next = START;
            end
            START: begin
                txd_next = START_BIT;
                if (tick) state_next = DATA;
            end
            DATA: begin
                txd_next = shift[0];
                if (tick && last_bit) state_next = STOP;
            end
            STOP: begin
                if (tick && last_bit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers: grant bookkeeping, bit counter and the registered line.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr  <= '0;
            grant   <= '0;
            bit_cnt <= '0;
            txd     <= TXD_IDLE;
        end else begin
            txd <= txd_next;
            if (handshake) begin
                grant   <= winner;
                rr_ptr  <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
                bit_cnt <= '0;
            end else if (tick && (state == DATA || state == STOP)) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
            end
        end
    end

    // Captured byte, shifted out LSB first; later input changes cannot disturb it.
    always_ff @(posedge clk_in) begin
        if (handshake) begin
            shift <= win_data;
        end else if (state == DATA && tick) begin
            shift <= shift >> 1;
        end
    end

    assign grant_id_out = grant;
    assign busy_out     = (state != IDLE);
    assign txd_out      = txd;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Bench for rs232_tx_arbiter: a frame-level reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized traffic phase.
module tb_rs232_tx_arbiter;

    localparam int NR   = 4;
    localparam int CD   = 4;
    localparam int DB   = 8;
    localparam int FR   = (1 + DB + 1) * CD;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    valid_a, ready_a, valid_b, ready_b;
    logic [NR*DB-1:0] data_a, data_b;
    logic [1:0]       grant_a, grant_b;
    logic             busy_a, txd_a, busy_b, txd_b;

    rs232_tx_arbiter #(.NUM_REQ(4), .CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(valid_a), .req_data_in(data_a),
        .req_ready_out(ready_a), .grant_id_out(grant_a), .busy_out(busy_a), .txd_out(txd_a));

    rs232_tx_arbiter #(.NUM_REQ(4), .CLK_DIV(1), .DATA_BITS(8), .STOP_BITS(2)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(valid_b), .req_data_in(data_b),
        .req_ready_out(ready_b), .grant_id_out(grant_b), .busy_out(busy_b), .txd_out(txd_b));

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // reference model state: cycles of busy left, pending line values, pointer, grant
    int m_left;
    int m_rr;
    int m_grant;
    bit m_txd;
    bit mq[$];

    bit txd_log[MAXC];
    bit busy_log[MAXC];
    bit txd_log_b[MAXC];
    bit busy_log_b[MAXC];
    int hs_cyc[$];
    int hs_id[$];
    int mhs_id[$];
    int bhs_cyc[$];
    int ready_cnt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int winner_of(input logic [NR-1:0] v, input int rr);
        for (int k = 0; k < NR; k++) begin
            if (v[(rr + k) % NR] === 1'b1) return (rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_left  = 0;
        m_rr    = 0;
        m_grant = 0;
        m_txd   = 1'b1;
        mq.delete();
    endtask

    // one clock: compare against the model, log, then advance the model across the edge
    task automatic step();
        logic [NR-1:0] exp_ready;
        int w;
        #1;
        w = winner_of(valid_a, m_rr);
        exp_ready = '0;
        if (m_left == 0 && w >= 0) exp_ready[w] = 1'b1;
        check("txd", int'(txd_a), int'(m_txd));
        check("busy", int'(busy_a), int'(m_left > 0));
        check("ready", int'(ready_a), int'(exp_ready));
        check("grant", int'(grant_a), m_grant);
        if (cyc < MAXC) begin
            txd_log[cyc]    = txd_a;
            busy_log[cyc]   = busy_a;
            txd_log_b[cyc]  = txd_b;
            busy_log_b[cyc] = busy_b;
        end
        if (ready_a != '0) ready_cnt++;
        if ((ready_a & valid_a) != '0) begin
            hs_cyc.push_back(cyc + 1);
            for (int i = 0; i < NR; i++) if (ready_a[i]) hs_id.push_back(i);
        end
        if ((ready_b & valid_b) != '0) bhs_cyc.push_back(cyc + 1);
        m_txd = (mq.size() > 0) ? mq.pop_front() : 1'b1;
        if (m_left > 0) begin
            m_left--;
        end else if (w >= 0) begin
            for (int j = 0; j < 1 + DB + 1; j++) begin
                bit v;
                if (j == 0)       v = 1'b0;
                else if (j <= DB) v = data_a[w*DB + j - 1];
                else              v = 1'b1;
                repeat (CD) mq.push_back(v);
            end
            m_grant = w;
            m_rr    = (w + 1) % NR;
            m_left  = FR;
            mhs_id.push_back(w);
        end
        @(negedge clk);
        cyc++;
    endtask

    // asynchronous reset pulse placed mid-cycle, outputs checked while it is held
    task automatic pulse_reset(input string name);
        #1 rst_n = 1'b0;
        #1;
        check({name, "_txd"}, int'(txd_a), 1);
        check({name, "_busy"}, int'(busy_a), 0);
        check({name, "_ready"}, int'(ready_a), 0);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_frame(input string name, input int t, input logic [9:0] bits);
        for (int b = 0; b < 10; b++) begin
            if (t + 1 + b*CD + 1 < MAXC)
                check(name, int'(txd_log[t + 1 + b*CD + 1]), int'(bits[b]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        logic [9:0]  f41, f5a;
        logic [10:0] fb;
        logic [2:0]  ord3;
        f41 = 10'b1010000010;
        f5a = 10'b1010110100;
        fb  = 11'b11101001010;

        valid_a = '0; data_a = '0; valid_b = '0; data_b = '0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_txd", int'(txd_a), 1);
        check("rst_busy", int'(busy_a), 0);
        check("rst_ready", int'(ready_a), 0);
        check("rst_grant", int'(grant_a), 0);
        check("rst_txd_b", int'(txd_b), 1);
        rst_n = 1'b1;

        // single requester 2 sending 0x41
        valid_a = 4'b0100;
        data_a[2*DB +: DB] = 8'h41;
        ready_cnt = 0;
        base = hs_cyc.size();
        step();
        valid_a = '0;
        data_a  = 32'hFFFF_FFFF;
        repeat (44) step();
        check("t1_frames", hs_cyc.size() - base, 1);
        check("t1_id", hs_id[base], 2);
        check("t1_ready_cycles", ready_cnt, 1);
        check("t1_grant_hold", int'(grant_a), 2);
        check_frame("t1_bit", hs_cyc[base], f41);

        // all four held: grant order 0,1,2,3,0 at 41-cycle spacing
        pulse_reset("t2_rst");
        valid_a = 4'hF;
        data_a  = $urandom;
        base = hs_cyc.size();
        t = mhs_id.size();
        repeat (5*41 + 2) step();
        valid_a = '0;
        repeat (45) step();
        for (int k = 0; k < 5; k++) begin
            check("t2_order", hs_id[base + k], k % 4);
            check("t2_model_order", mhs_id[t + k], k % 4);
        end
        for (int k = 0; k < 4; k++)
            check("t2_spacing", hs_cyc[base + k + 1] - hs_cyc[base + k], 41);
        check("t2_busy_end", int'(busy_log[hs_cyc[base] + 39]), 1);
        check("t2_idle_gap", int'(busy_log[hs_cyc[base] + 40]), 0);

        // req 1 held, req 3 joins mid-frame: 3,1,3 alternation
        pulse_reset("t3_rst");
        valid_a = 4'b0010;
        data_a  = $urandom;
        base = hs_cyc.size();
        step();
        repeat (10) step();
        valid_a = 4'b1010;
        repeat (3*41 + 5) step();
        valid_a = '0;
        repeat (45) step();
        ord3 = 3'b101;
        check("t3_first", hs_id[base], 1);
        for (int k = 0; k < 3; k++)
            check("t3_alt", hs_id[base + 1 + k], ord3[k] ? 3 : 1);

        // reset in the middle of the data bits, then a clean frame from req 0
        pulse_reset("t4_pre");
        valid_a = 4'b0001;
        data_a  = 32'h0000_00C3;
        step();
        valid_a = '0;
        repeat (15) step();
        pulse_reset("t4_mid");
        valid_a = 4'b0001;
        data_a  = 32'h0000_005A;
        base = hs_cyc.size();
        step();
        valid_a = '0;
        repeat (44) step();
        check("t4_id", hs_id[base], 0);
        check_frame("t4_bit", hs_cyc[base], f5a);

        // req 0 valid only while busy: no frame, pointer stays after req 1
        pulse_reset("t5_rst");
        valid_a = 4'b0010;
        data_a  = $urandom;
        base = hs_cyc.size();
        step();
        valid_a = '0;
        repeat (5) step();
        valid_a = 4'b0001;
        repeat (10) step();
        valid_a = '0;
        repeat (40) step();
        check("t5_no_frame", hs_cyc.size() - base, 1);
        valid_a = 4'b1001;
        step();
        valid_a = '0;
        repeat (44) step();
        check("t5_next_id", hs_id[base + 1], 3);

        // randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0) valid_a = 4'($urandom);
            data_a = $urandom;
            step();
        end
        valid_a = '0;
        repeat (45) step();

        // second instance: one clock per bit, two stop bits
        valid_b = 4'b0001;
        data_b  = 32'h0000_00A5;
        base = bhs_cyc.size();
        repeat (30) step();
        valid_b = '0;
        repeat (15) step();
        t = bhs_cyc[base];
        check("t6_spacing", bhs_cyc[base + 1] - t, 12);
        check("t6_busy_first", int'(busy_log_b[t]), 1);
        check("t6_busy_last", int'(busy_log_b[t + 10]), 1);
        check("t6_busy_gap", int'(busy_log_b[t + 11]), 0);
        check("t6_busy_next", int'(busy_log_b[t + 12]), 1);
        for (int j = 0; j < 11; j++)
            check("t6_bit", int'(txd_log_b[t + 1 + j]), int'(fb[j]));
        check("t6_gap_high", int'(txd_log_b[t + 12]), 1);
        check("t6_next_start", int'(txd_log_b[t + 13]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
